// File: rtl/lockstep_equiv_checker.sv
// Lockstep golden-vs-netlist checker: drives shared LFSR stimulus and reset, compares outputs; STOP_ON_FAIL_EN halts at the first mismatch.
// Latency: RST_CYCLES cycles of DUT reset, then SETTLE_CYCLES per vector; done follows the compare of vector NUM_VECTORS.
// Backpressure: none; start is ignored while busy and restarts the run from IDLE or DONE.
module lockstep_equiv_checker #(
  parameter int          IN_W          = 32,
  parameter int          OUT_W         = 32,
  parameter int          NUM_VECTORS   = 1000,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          RST_CYCLES    = 2,
  parameter logic [31:0] SEED          = 32'h0000_0001,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  output logic             dut_rst,
  input  logic [OUT_W-1:0] golden_out,
  input  logic [OUT_W-1:0] netlist_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] vec_idx,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [OUT_W-1:0] first_fail_golden,
  output logic [OUT_W-1:0] first_fail_netlist
);

  typedef enum logic [1:0] {IDLE, RESET_DUT, RUN, DONE} state_t;

  localparam int TMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  // The vector counter may need more bits than the reported index when CNT_W is narrow.
  localparam int VNEED = $clog2(NUM_VECTORS + 1);
  localparam int VW    = (VNEED > CNT_W) ? VNEED : CNT_W;
  localparam logic [31:0]      POLY    = 32'h8020_0003;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t         state_q, state_d;
  logic [TW-1:0]  tmr_q;
  logic [VW-1:0]  vcnt_q;
  logic [31:0]    lfsr_q;
  logic           mismatch;
  logic           stop_hit;
  logic           cmp_now;
  logic           load_now;
  logic           start_run;
  logic           enter_done;

`ifdef SYNTHESIS
  assign mismatch = (golden_out != netlist_out);
`else
  assign mismatch = (golden_out !== netlist_out) || $isunknown(golden_out) || $isunknown(netlist_out);
`endif

`ifdef STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  assign vec_idx = CNT_W'(vcnt_q);
  assign pass    = done && (mismatch_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmp_now    = 1'b0;
    load_now   = 1'b0;
    start_run  = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_d   = RESET_DUT;
        end
      end
      RESET_DUT: begin
        if (tmr_q == TW'(RST_CYCLES - 1)) begin
          cmp_now = 1'b1;
          if (stop_hit) begin
            enter_done = 1'b1;
            state_d    = DONE;
          end else begin
            load_now = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
          cmp_now = 1'b1;
          if (stop_hit || (vcnt_q >= VW'(NUM_VECTORS))) begin
            enter_done = 1'b1;
            state_d    = DONE;
          end else begin
            load_now = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr_q              <= '0;
      vcnt_q             <= '0;
      lfsr_q             <= SEED;
      stim               <= '0;
      dut_rst            <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      mismatch_cnt       <= '0;
      first_fail_valid   <= 1'b0;
      first_fail_idx     <= '0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else if (start_run) begin
      tmr_q              <= '0;
      vcnt_q             <= '0;
      lfsr_q             <= SEED;
      stim               <= '0;
      dut_rst            <= 1'b1;
      busy               <= 1'b1;
      done               <= 1'b0;
      mismatch_cnt       <= '0;
      first_fail_valid   <= 1'b0;
      first_fail_idx     <= '0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else begin
      if (state_q == RESET_DUT || state_q == RUN)
        tmr_q <= load_now ? '0 : tmr_q + 1'b1;
      if (cmp_now && mismatch) begin
        if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (!first_fail_valid) begin
          first_fail_valid   <= 1'b1;
          first_fail_idx     <= CNT_W'(vcnt_q);
          first_fail_golden  <= golden_out;
          first_fail_netlist <= netlist_out;
        end
      end
      // Stimulus and LFSR move together, once per vector.
      if (load_now) begin
        stim    <= lfsr_q[IN_W-1:0];
        lfsr_q  <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
        vcnt_q  <= vcnt_q + 1'b1;
        dut_rst <= 1'b0;
      end
      if (enter_done) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        dut_rst <= 1'b0;
      end
    end
  end

endmodule
